// File: rtl/data_memory_dump_if.sv
// -----------------------------------------------------------------------------
// data_memory_dump_if
// Host-side access bus of the data memory.
//   rd_en    : read enable (combinational read)
//   wr_en    : write enable (applied at posedge clk)
//   addr     : byte address
//   be       : byte enables for writes, bit i selects byte i
//   wdata    : write data
//   rdata    : read data, zero when not reading or when the access is rejected
//   addr_err : registered one-cycle flag for a rejected access in the previous cycle
// Modports: master drives the request, slave (the memory) returns data/status.
// -----------------------------------------------------------------------------
interface data_memory_dump_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;
    logic                  addr_err;

    modport master (
        output rd_en, wr_en, addr, be, wdata,
        input  rdata, addr_err
    );

    modport slave (
        input  rd_en, wr_en, addr, be, wdata,
        output rdata, addr_err
    );
endinterface

// File: rtl/data_memory_dump.sv
// -----------------------------------------------------------------------------
// data_memory_dump
// Word-organised data memory with byte-enabled writes, combinational reads,
// range checking and a test-dump sequencer. When the trigger word holds the
// trigger value, a window of DUMP_LEN words starting at DUMP_BASE is streamed
// out of test_port, once per trigger event.
//
// Ports:
//   clk        : clock, all state changes on posedge
//   rst_n      : synchronous active-low reset (memory contents are kept)
//   bus        : data_memory_dump_if.slave host access bus
//   test_port  : dumped word
//   test_valid : test_port carries a dump word this cycle
//   dump_done  : dump finished, trigger still present
//
// Build option: define DMEM_ALIGN_CHECK_EN to reject accesses whose byte
// offset within the word is non-zero (treated like an out-of-range access).
// Without it the offset bits are ignored.
//
// FSM states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for the trigger word to hold TRIG_VAL
//   DUMP    | streaming mem[DUMP_BASE+cnt], one word per cycle
//   DONE    | window sent; wait for the trigger to drop before re-arming
// -----------------------------------------------------------------------------
module data_memory_dump #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 32,
    parameter int TRIG_IDX  = 100,
    parameter int TRIG_VAL  = 9,
    parameter int DUMP_BASE = 0,
    parameter int DUMP_LEN  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_memory_dump_if.slave    bus,
    output logic [DATA_W-1:0]    test_port,
    output logic                 test_valid,
    output logic                 dump_done
);

    localparam int NBYTES = DATA_W / 8;
    localparam int OFF_W  = (NBYTES > 1) ? $clog2(NBYTES) : 0;
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DUMP_LEN) + 1;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [MEM_IW-1:0] mem_idx;
    logic              in_range;
    logic              misalign;
    logic              acc_ok;
    logic              wr_ok;
    logic [DATA_W-1:0] rdata_d;
    logic              addr_err_d;
    logic              addr_err_q;
    logic              trig;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [MEM_IW-1:0] dump_idx;
    logic [DATA_W-1:0] test_port_q;
    logic              test_valid_q;
    logic              dump_done_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign idx      = bus.addr[ADDR_W-1:OFF_W];
    assign in_range = (idx < IDX_W'(DEPTH));
    // Only meaningful when in range; out-of-range accesses never touch mem_q.
    assign mem_idx  = idx[MEM_IW-1:0];

    generate
        if (OFF_W > 0) begin : g_align
            assign misalign = ALIGN_CHK && (bus.addr[OFF_W-1:0] != '0);
        end else begin : g_no_align
            assign misalign = 1'b0;
        end
    endgenerate

    assign acc_ok = in_range && !misalign;
    assign wr_ok  = bus.wr_en && acc_ok;

    // ------------------------------------------------------------------
    // Host read port (combinational, pre-edge contents)
    // ------------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        if (bus.rd_en && acc_ok) begin
            rdata_d = mem_q[mem_idx];
        end
    end

    assign bus.rdata = rdata_d;

    // ------------------------------------------------------------------
    // Host write port; array is intentionally not reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (bus.be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Access error flag: reflects the previous cycle only, so back-to-back
    // bad accesses keep it high and a single one gives a one-cycle pulse.
    // ------------------------------------------------------------------
    always_comb begin
        addr_err_d = (bus.rd_en || bus.wr_en) && !acc_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.addr_err = addr_err_q;

    // ------------------------------------------------------------------
    // Dump sequencer (private read port, independent of host traffic)
    // ------------------------------------------------------------------
    assign trig     = (mem_q[TRIG_IDX] == DATA_W'(TRIG_VAL));
    assign dump_idx = MEM_IW'(DUMP_BASE) + MEM_IW'(cnt_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            test_port_q  <= '0;
            test_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    test_valid_q <= 1'b0;
                    dump_done_q  <= 1'b0;
                    if (trig) begin
                        state_q <= ST_DUMP;
                        cnt_q   <= '0;
                    end
                end
                ST_DUMP: begin
                    test_port_q  <= mem_q[dump_idx];
                    test_valid_q <= 1'b1;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DUMP_LEN - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // test_port keeps the last dumped word
                    test_valid_q <= 1'b0;
                    if (trig) begin
                        dump_done_q <= 1'b1;
                    end else begin
                        dump_done_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    test_valid_q <= 1'b0;
                    dump_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign test_port  = test_port_q;
    assign test_valid = test_valid_q;
    assign dump_done  = dump_done_q;

endmodule
